// File: rtl/xbar_pkg.sv
// Shared definitions for the 1x4 crossbar and its ingress FIFO.
// Port count, select width, default payload width and the port-index type.
package xbar_pkg;

    localparam int NPORTS        = 4;
    localparam int PORT_W        = 2;
    localparam int DEFAULT_WIDTH = 320;

    typedef logic [PORT_W-1:0] port_idx_t;

    // One-hot decode of a port index, as seen on per-port valid/ready buses.
    function automatic logic [NPORTS-1:0] port_onehot(input port_idx_t port);
        return NPORTS'(1) << port;
    endfunction

endpackage

// File: rtl/xbar_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; the owner gates stale entries off its outputs.
module xbar_fifo_ram #(
    parameter int WIDTH  = 322,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: no reset on the array -- a reset here would turn cheap RAM into flops
    // and buy nothing, because entries are only ever read after being written.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/xbar_ingress_fifo.sv
// Ingress FIFO in front of a 1x4 crossbar: stores {dest, payload} flits in order
// and presents the head flit as a one-hot valid plus data/select for the crossbar.
module xbar_ingress_fifo
    import xbar_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  port_idx_t                    in_dest,
    output logic [WIDTH-1:0]             out_data,
    output port_idx_t                    sel_out,
    output logic [NPORTS-1:0]            out_valid,
    input  logic [NPORTS-1:0]            out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = WIDTH + PORT_W;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] head_entry;
    logic [WIDTH-1:0]   head_data;
    port_idx_t          head_dest;
    logic               not_empty;
    logic               push;
    logic               pop;

    xbar_fifo_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_dest, in_data}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_entry)
    );

    assign {head_dest, head_data} = head_entry;

    // in_ready depends only on count_q, so a same-cycle pop never frees a slot early.
    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = not_empty && out_ready[head_dest];

    // NOTE: combinational next-state uses blocking '=' with every output defaulted
    // first, so no path can leave a variable unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Empty FIFO shows all-zero head so stale storage never leaks to the crossbar.
    assign out_valid = not_empty ? port_onehot(head_dest) : '0;
    assign out_data  = not_empty ? head_data : '0;
    assign sel_out   = not_empty ? head_dest : '0;
    assign count     = count_q;

endmodule
